cache_perf_reader: RTL
======================

Name: cache_perf_reader

Overview:
- Hardware-side collector for the I-cache and D-cache access/miss event streams that today go only to the simulator.
- Counts accesses and misses per cache in saturating counters.
- Lets software capture all four counters atomically into a snapshot.
- Exposes snapshot and status through a one-entry valid/ready read port (MMIO/CSR side), so firmware reads hit/miss statistics on both simulator and FPGA builds.

Parameters:
- CNT_W, 64: width of each counter, snapshot register and read data.
- ADDR_W, 3: read address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ic_valid  in  1  I-cache access event this cycle
- ic_miss  in  1  I-cache access was a miss; qualified by ic_valid
- dc_valid  in  1  D-cache access event this cycle
- dc_miss  in  1  D-cache access was a miss; qualified by dc_valid
- cnt_en  in  1  global count enable
- clear  in  1  zero all live counters and saturation flags
- snap  in  1  copy live counters into snapshot registers
- rd_req_valid  in  1  read request
- rd_req_ready  out  1  request accepted when valid and ready both high
- rd_addr  in  ADDR_W  register index
- rd_resp_valid  out  1  response valid
- rd_resp_ready  in  1  consumer takes response
- rd_data  out  CNT_W  read data
- rd_err  out  1  bad address

Behaviour:
- Reset (rst high at posedge): all live counters, snapshots, sticky flags, snap_cnt, rd_resp_valid, rd_data and rd_err become 0. rst overrides every other input.
- Live counters:
  - IA increments on ic_valid & cnt_en.
  - IM increments on ic_valid & ic_miss & cnt_en.
  - DA and DM follow the same rules using dc_valid and dc_miss.
  - A miss bit with its valid low is ignored.
  - Increment is by 1 per cycle at most.
- Saturation: a counter at all-ones stays at all-ones; its sticky flag (sat[0..3] for IA, IM, DA, DM) sets on the first increment attempted at all-ones. Flags clear only on clear or rst.
- clear: next-cycle live counters = 0 and flags = 0. Clear wins over a same-cycle event, which is dropped. Snapshots are not affected.
- snap:
  - Snapshot registers load the live counter register values present before this edge's update.
  - snap together with clear captures the pre-clear values.
  - snap_cnt (16-bit, wraps 0xFFFF to 0) increments on each snap.
- Read map:
  - 0: snapshot IA
  - 1: snapshot IM
  - 2: snapshot DA
  - 3: snapshot DM
  - 4: status = {zero-extend, snap_cnt[15:0] at bits 19:4, sat[3:0] at bits 3:0}
  - 5 to 7: rd_err = 1, rd_data = 0
- Read handshake:
  - rd_req_ready = !rd_resp_valid | rd_resp_ready (combinational, single-entry pipeline).
  - On accept, rd_data and rd_err are registered and rd_resp_valid = 1 on the next cycle: one-cycle latency.
  - Data is sampled at the accept edge, so a snap in the same cycle returns the old snapshot.
  - The response holds stable while rd_resp_valid & !rd_resp_ready.
  - Back-to-back accept with ready held high gives one response per cycle.
  - When the response is taken with no new accept, rd_resp_valid drops to 0; rd_data keeps its last value.
- Reset mid-transaction drops any pending response (rd_resp_valid = 0 next cycle).

Decomposition:
- Package cache_perf_pkg holds:
  - CNT_W default
  - address constants ADDR_IA = 0, ADDR_IM = 1, ADDR_DA = 2, ADDR_DM = 3, ADDR_STATUS = 4
  - status field bit positions
- Sub-module perf_sat_counter:
  - Ports: clk, rst, clear, inc, out count, out sat.
  - Implements the saturating counter with sticky flag.
  - Instantiated four times.
  - Snapshot logic, status register and read port stay in the top.

Test Plan:
- Reset, then 10 cycles of ic_valid = 1 with ic_miss = 1 on 3 of them and cnt_en = 1, then snap, then read addr 0 and 1 -> rd_data 10 then 3, each rd_resp_valid one cycle after accept.
- dc_valid = 0 with dc_miss = 1 for 5 cycles, then snap, then read addr 3 -> 0. Repeat with cnt_en = 0 and dc_valid = 1 -> 0.
- CNT_W = 8: drive 300 I-cache accesses, snap, read addr 0 -> 0xFF; read addr 4 -> sat[0] = 1, snap_cnt = 1. Then clear, snap, read addr 4 -> sat = 0, snap_cnt = 2.
- clear, snap and ic_valid asserted in the same cycle with IA = 7 -> snapshot IA = 7; one cycle later live IA = 0 (event dropped), confirmed by a second snap reading 0.
- Hold rd_resp_ready = 0 after accepting a read of addr 2 -> rd_req_ready = 0, rd_data stable for 4 cycles. Then raise rd_resp_ready with a new request pending -> back-to-back responses, no loss or duplication.
- Read addr 6 -> rd_err = 1, rd_data = 0. Assert rst while rd_resp_valid = 1 -> rd_resp_valid = 0 and all counters read 0 after reset.

Source files
------------

// File: rtl/cache_perf_pkg.sv
// Shared constants for the cache performance counter block:
// read-map addresses, status field layout and default widths.
package cache_perf_pkg;
  localparam int CNT_W_DEF   = 64;
  localparam int N_CNT       = 4;
  localparam int ADDR_IA     = 0;
  localparam int ADDR_IM     = 1;
  localparam int ADDR_DA     = 2;
  localparam int ADDR_DM     = 3;
  localparam int ADDR_STATUS = 4;
  localparam int ST_SAT_LSB  = 0;
  localparam int ST_SAT_W    = 4;
  localparam int ST_SNAP_LSB = 4;
  localparam int ST_SNAP_W   = 16;
  localparam int ST_W        = 20;
endpackage

// File: rtl/perf_sat_counter.sv
// Saturating event counter with a sticky overflow-attempt flag.
// clear and rst zero both the count and the flag.
module perf_sat_counter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         sat
);
  logic [W-1:0] r_count;
  logic         r_sat;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (inc) begin
      if (&r_count) r_sat <= 1'b1;
      else          r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;
  assign sat   = r_sat;
endmodule

// File: rtl/cache_perf_reader.sv
// I/D-cache access and miss counters with atomic snapshot
// and a single-entry valid/ready read port.
module cache_perf_reader
  import cache_perf_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_valid,
  input  logic              ic_miss,
  input  logic              dc_valid,
  input  logic              dc_miss,
  input  logic              cnt_en,
  input  logic              clear,
  input  logic              snap,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_resp_valid,
  input  logic              rd_resp_ready,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_err
);
  logic [N_CNT-1:0] w_inc;
  logic [N_CNT-1:0] w_sat;
  logic [CNT_W-1:0] w_cnt [N_CNT];
  logic [CNT_W-1:0] r_snap [N_CNT];
  logic [ST_SNAP_W-1:0] r_snap_cnt;
  logic [ST_W-1:0]  w_stat;
  logic [CNT_W-1:0] w_rdata;
  logic             w_err;
  logic             w_accept;
  logic             r_resp_valid;
  logic [CNT_W-1:0] r_data;
  logic             r_err;

  assign w_inc[0] = ic_valid & cnt_en;
  assign w_inc[1] = ic_valid & ic_miss & cnt_en;
  assign w_inc[2] = dc_valid & cnt_en;
  assign w_inc[3] = dc_valid & dc_miss & cnt_en;

  for (genvar g = 0; g < N_CNT; g++) begin : g_cnt
    perf_sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .inc   (w_inc[g]),
      .count (w_cnt[g]),
      .sat   (w_sat[g])
    );
  end

  // Snapshot sees the pre-edge counts, so snap+clear keeps old values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CNT; i++) r_snap[i] <= '0;
      r_snap_cnt <= '0;
    end else if (snap) begin
      for (int i = 0; i < N_CNT; i++) r_snap[i] <= w_cnt[i];
      r_snap_cnt <= r_snap_cnt + 1'b1;
    end
  end

  assign w_stat[ST_SAT_LSB +: ST_SAT_W]   = w_sat;
  assign w_stat[ST_SNAP_LSB +: ST_SNAP_W] = r_snap_cnt;

  always_comb begin
    w_rdata = '0;
    w_err   = 1'b0;
    case (int'(rd_addr))
      ADDR_IA:     w_rdata = r_snap[0];
      ADDR_IM:     w_rdata = r_snap[1];
      ADDR_DA:     w_rdata = r_snap[2];
      ADDR_DM:     w_rdata = r_snap[3];
      ADDR_STATUS: w_rdata = CNT_W'(w_stat);
      default:     w_err   = 1'b1;
    endcase
  end

  assign rd_req_ready = !r_resp_valid || rd_resp_ready;
  assign w_accept     = rd_req_valid && rd_req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_data       <= '0;
      r_err        <= 1'b0;
    end else if (w_accept) begin
      r_resp_valid <= 1'b1;
      r_data       <= w_rdata;
      r_err        <= w_err;
    end else if (rd_resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

  assign rd_resp_valid = r_resp_valid;
  assign rd_data       = r_data;
  assign rd_err        = r_err;
endmodule
